seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit, common-anode seven-segment display.
- Holds a 32-bit hex value as 8 nibbles and drives one anode at a time, at a rate that shows all 8 digits as lit.
- Inserts a blanking gap between digits to stop ghosting. Takes new values through a load pulse and applies them only at frame boundaries, so the display never shows a mix of old and new digits.
- Sits between the arithmetic/operation logic and the board pins, replacing static all-anodes drive.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, state encoding and helpers for the seven-segment scan controller.
// The display record groups one frame's worth of digit data (value, decimal points, enables).
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] val;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
   } disp_t;

   // Active-low a..g patterns (bit6 = a, bit0 = g), indexed by nibble.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06,
      7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60,
      7'h31, 7'h42, 7'h30, 7'h38
   };

   // Bit i set when nibbles NUM_DIGITS-1..i are all zero; digit 0 never qualifies.
   function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] v);
      logic [NUM_DIGITS-1:0] m;
      logic                  all_zero;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (v[4*i +: 4] == 4'h0);
         m[i]     = all_zero;
      end
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit time-multiplexed seven-segment scanner with blanking gap and frame-synchronous load.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shows).
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int PRESCALE = 100000,  // cycles per digit slot, >= 4
   parameter int BLANK    = 1000     // dark cycles at the start of each slot, 1..PRESCALE-1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   input  logic        load,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  en_mask,
   output logic [7:0]  an,
   output logic [6:0]  a_to_g,
   output logic        dp_n,
   output logic        frame_done,
   output logic        pending
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   state_t        state, state_nxt;
   disp_t         staging, shadow, load_data;

   logic          cnt_last, frame_wrap;
   logic [6:0]    seg_dec, seg_show;
   logic [7:0]    an_d;
   logic [6:0]    seg_d;
   logic          dpn_d;

   assign cnt_last   = (cnt == CW'(PRESCALE - 1));
   assign frame_wrap = cnt_last && (idx == LAST_DIGIT);
   assign load_data  = '{val: value, dp: dp_mask, en: en_mask};

   seg7_decode u_decode (
      .nibble (shadow.val[{idx, 2'b00} +: 4]),
      .seg    (seg_dec)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_dark;
   assign lz_dark  = lead_zero_mask(shadow.val);
   assign seg_show = lz_dark[idx] ? SEG_OFF : seg_dec;
`else
   assign seg_show = seg_dec;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         state <= ST_BLANK;
      end else begin
         state <= state_nxt;
         if (cnt_last) begin
            cnt <= '0;
            idx <= idx + IW'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      an_d      = AN_OFF;
      seg_d     = SEG_OFF;
      dpn_d     = 1'b1;
      unique case (state)
         ST_BLANK: begin
            if (cnt == CW'(BLANK - 1)) state_nxt = ST_SHOW;
         end
         ST_SHOW: begin
            if (cnt_last) state_nxt = ST_BLANK;
            if (shadow.en[idx]) begin
               an_d  = ~(8'b1 << idx);
               seg_d = seg_show;
               dpn_d = ~shadow.dp[idx];
            end
         end
      endcase
   end

   // Pins are driven only from flops, one cycle behind the state that selects them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= AN_OFF;
         a_to_g     <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_d;
         a_to_g     <= seg_d;
         dp_n       <= dpn_d;
         frame_done <= (cnt == CW'(PRESCALE - 2)) && (idx == LAST_DIGIT);
      end
   end

   // NOTE: staging and shadow are ordinary flops, not RAM, so they take the reset like everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staging <= '0;
         shadow  <= '0;
         pending <= 1'b0;
      end else if (frame_wrap) begin
         pending <= 1'b0;
         if (load) begin
            staging <= load_data;
            shadow  <= load_data;
         end else begin
            shadow  <= staging;
         end
      end else if (load) begin
         staging <= load_data;
         pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl with PRESCALE=8, BLANK=2 (one frame = 64 cycles).
// Every cycle's expected pins are predicted from the edge count and the loads applied, then compared.
module tb_seg7_scan_ctrl;

   localparam int PRESCALE = 8;
   localparam int BLANK    = 2;
   localparam int FRAME    = 8 * PRESCALE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [31:0] value = '0;
   logic [7:0]  dp_mask = '0;
   logic [7:0]  en_mask = '0;
   logic [7:0]  an;
   logic [6:0]  a_to_g;
   logic        dp_n, frame_done, pending;

   seg7_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .load       (load),
      .dp_mask    (dp_mask),
      .en_mask    (en_mask),
      .an         (an),
      .a_to_g     (a_to_g),
      .dp_n       (dp_n),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp_n;
      logic       fd;
      logic       pend;
   } obs_t;

   localparam obs_t RESET_OBS = '{an: 8'hFF, seg: 7'h7F, dp_n: 1'b1, fd: 1'b0, pend: 1'b0};

   localparam logic [6:0] SEG_EXP [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   typedef struct {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  en;
      int          probe;
      logic [7:0]  an;
      logic [6:0]  seg;
      logic        dp_n;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   n_edges = 0;
   obs_t exp_q[$];

   logic [31:0] m_sval = '0, m_tval = '0;
   logic [7:0]  m_sdp = '0, m_sen = '0, m_tdp = '0, m_ten = '0;
   logic        m_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference model: after edge n the pins reflect position n-1 of the scan.
   always @(posedge clk) begin
      if (rst) begin
         n_edges = 0;
         m_sval = '0; m_sdp = '0; m_sen = '0;
         m_tval = '0; m_tdp = '0; m_ten = '0;
         m_pend = 1'b0;
      end else begin
         int   pos;
         int   d;
         obs_t e;
         n_edges++;
         pos = n_edges - 1;
         e   = RESET_OBS;
         if ((pos % PRESCALE) >= BLANK) begin
            d = (pos / PRESCALE) % 8;
            if (m_sen[d]) begin
               e.an   = ~(8'd1 << d);
               e.seg  = SEG_EXP[m_sval[4*d +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
               if (d > 0 && (m_sval >> (4*d)) == 32'd0) e.seg = 7'h7F;
`endif
               e.dp_n = ~m_sdp[d];
            end
         end
         if ((pos % FRAME) == FRAME - 1) begin
            if (load) begin
               m_sval = value; m_sdp = dp_mask; m_sen = en_mask;
               m_tval = value; m_tdp = dp_mask; m_ten = en_mask;
            end else begin
               m_sval = m_tval; m_sdp = m_tdp; m_sen = m_ten;
            end
            m_pend = 1'b0;
         end else if (load) begin
            m_tval = value; m_tdp = dp_mask; m_ten = en_mask;
            m_pend = 1'b1;
         end
         e.fd   = ((n_edges % FRAME) == FRAME - 1);
         e.pend = m_pend;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      obs_t a;
      obs_t e;
      a = {an, a_to_g, dp_n, frame_done, pending};
      if (rst) begin
         exp_q.delete();
         check("reset_state", 32'(a), 32'(RESET_OBS));
      end else begin
         e = (exp_q.size() == 0) ? RESET_OBS : exp_q.pop_front();
         check($sformatf("scan n=%0d", n_edges), 32'(a), 32'(e));
         check("one_anode_low", 32'($countones(~an) <= 1), 32'd1);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_mod(input int m);
      int k = 0;
      do begin
         step();
         k++;
      end while ((n_edges % FRAME) != m && k < 3 * FRAME);
      if ((n_edges % FRAME) != m) begin
         checks++;
         failures++;
         $display("FAIL wait_mod: position %0d never reached, at %0d", m, n_edges % FRAME);
      end
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
      value   = v;
      dp_mask = dp;
      en_mask = en;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [6];
      logic [7:0] an_req;

      vecs[0] = '{value: 32'h7654_3210, dp: 8'h00, en: 8'hFF, probe: 2, an: 8'hFB, seg: 7'h12, dp_n: 1'b1};
      vecs[1] = '{value: 32'hFEDC_BA98, dp: 8'hAA, en: 8'hFF, probe: 5, an: 8'hDF, seg: 7'h42, dp_n: 1'b0};
      vecs[2] = '{value: 32'h89AB_CDEF, dp: 8'h01, en: 8'hF0, probe: 0, an: 8'hFF, seg: 7'h7F, dp_n: 1'b1};
      vecs[3] = '{value: 32'h0000_0A00, dp: 8'h00, en: 8'hFF, probe: 2, an: 8'hFB, seg: 7'h08, dp_n: 1'b1};
      vecs[4] = '{value: 32'h0000_0000, dp: 8'hFF, en: 8'hFF, probe: 0, an: 8'hFE, seg: 7'h01, dp_n: 1'b0};
      vecs[5] = '{value: 32'hDEAD_BEEF, dp: 8'h5A, en: 8'h3C, probe: 4, an: 8'hEF, seg: 7'h42, dp_n: 1'b0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check("pending_after_reset", 32'(pending), 32'd0);

      // First load lands 20 edges before the frame boundary.
      wait_mod(43);
      do_load(32'h7654_3210, 8'h00, 8'hFF);
      check("pending_set", 32'(pending), 32'd1);
      wait_mod(63);
      check("frame_done_at_wrap", 32'(frame_done), 32'd1);
      check("pending_held_to_wrap", 32'(pending), 32'd1);
      step();
      check("pending_cleared", 32'(pending), 32'd0);
      check("frame_done_one_cycle", 32'(frame_done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         wait_mod(8 * i + 5);
         an_req = ~(8'd1 << i);
         check($sformatf("digit%0d_an", i), 32'(an), 32'(an_req));
         check($sformatf("digit%0d_seg", i), 32'(a_to_g), 32'(SEG_EXP[i]));
      end
      repeat (3 * FRAME) step();

      for (int v = 0; v < 6; v++) begin
         wait_mod(10);
         do_load(vecs[v].value, vecs[v].dp, vecs[v].en);
         wait_mod(0);
         wait_mod(vecs[v].probe * 8 + 5);
         check($sformatf("vec%0d_an", v), 32'(an), 32'(vecs[v].an));
         check($sformatf("vec%0d_seg", v), 32'(a_to_g), 32'(vecs[v].seg));
         check($sformatf("vec%0d_dp_n", v), 32'(dp_n), 32'(vecs[v].dp_n));
      end

      // Two loads in one frame: the later one is applied.
      wait_mod(10);
      do_load(32'h0000_0001, 8'h00, 8'hFF);
      wait_mod(20);
      do_load(32'h0000_0002, 8'h00, 8'hFF);
      wait_mod(63);
      check("pending_before_boundary", 32'(pending), 32'd1);
      wait_mod(5);
      check("last_load_wins_an", 32'(an), 32'hFE);
      check("last_load_wins_seg", 32'(a_to_g), 32'h12);

      // Load sampled on the wrap edge goes straight to the display.
      wait_mod(63);
      check("wrap_cycle_frame_done", 32'(frame_done), 32'd1);
      do_load(32'hCAFE_F00D, 8'h00, 8'hFF);
      check("wrap_load_pending", 32'(pending), 32'd0);
      wait_mod(5);
      check("wrap_load_digit0_seg", 32'(a_to_g), 32'h42);
      wait_mod(61);
      check("wrap_load_digit7_an", 32'(an), 32'h7F);
      check("wrap_load_digit7_seg", 32'(a_to_g), 32'h31);

      // Reset in digit 5's SHOW slot with a load still waiting.
      wait_mod(10);
      do_load(32'h1234_5678, 8'h00, 8'hFF);
      wait_mod(45);
      check("pre_reset_digit5_an", 32'(an), 32'hDF);
      rst = 1'b1;
      #1;
      check("async_reset_an", 32'(an), 32'hFF);
      check("async_reset_seg", 32'(a_to_g), 32'h7F);
      check("async_reset_pending", 32'(pending), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      wait_mod(63);
      check("restart_frame_done", 32'(frame_done), 32'd1);
      step();
      wait_mod(10);
      do_load(32'h0000_0005, 8'h00, 8'hFF);
      wait_mod(0);
      wait_mod(2);
      check("restart_blank_an", 32'(an), 32'hFF);
      step();
      check("restart_digit0_an", 32'(an), 32'hFE);
      check("restart_digit0_seg", 32'(a_to_g), 32'h24);
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
